pin_entry_collector: RTL and testbench

Keypad front-end for the door controller. Assembles four BCD digits typed on the keypad into a 16-bit PIN word. When ENTER is pressed, it presents that word to the gate manager's `pass` input together with a one-cycle `pass_valid` strobe. It sits directly upstream of the gate manager. It also flags malformed key sequences and, optionally, abandons stale partial entries.

---
 rtl/pin_entry_collector.sv | 159 +++++++++++++++
 tb/tb_pin_entry_collector.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pin_entry_collector.sv
// Keypad front-end: collects four BCD digits and presents them as a PIN on ENTER.
// Define PIN_TIMEOUT_EN to discard stale partial entries after TIMEOUT_CYCLES idle cycles.
module pin_entry_collector #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_key_valid,
    input  logic [3:0]  i_key_code,
    output logic [15:0] o_pass,
    output logic        o_pass_valid,
    output logic [2:0]  o_digit_cnt,
    output logic        o_busy,
    output logic        o_key_error,
    output logic        o_timeout,
    output logic [1:0]  o_state
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    state_t      r_state;
    logic [15:0] r_sr;
    logic [2:0]  r_cnt;
    logic [15:0] r_pass;
    logic        r_pass_valid;
    logic        r_key_error;

    state_t      w_state_nxt;
    logic [15:0] w_sr_nxt;
    logic [2:0]  w_cnt_nxt;
    logic [15:0] w_pass_nxt;
    logic        w_pass_valid_nxt;
    logic        w_key_error_nxt;
    logic        w_is_digit;
    logic        w_expire;

    assign w_is_digit = (i_key_code <= 4'd9);

    // A valid key always takes precedence over a coincident timeout expiry.
    always_comb begin
        w_state_nxt      = r_state;
        w_sr_nxt         = r_sr;
        w_cnt_nxt        = r_cnt;
        w_pass_nxt       = r_pass;
        w_pass_valid_nxt = 1'b0;
        w_key_error_nxt  = 1'b0;
        if (i_key_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_digit) begin
                        w_state_nxt = ST_COLLECT;
                        w_sr_nxt    = {r_sr[11:0], i_key_code};
                        w_cnt_nxt   = 3'd1;
                    end else if (i_key_code != KEY_CLEAR) begin
                        w_key_error_nxt = 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (w_is_digit) begin
                        w_sr_nxt  = {r_sr[11:0], i_key_code};
                        w_cnt_nxt = r_cnt + 3'd1;
                        if (r_cnt == 3'd3) w_state_nxt = ST_FULL;
                    end else if (i_key_code == KEY_CLEAR) begin
                        w_state_nxt = ST_IDLE;
                        w_sr_nxt    = 16'h0000;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_key_error_nxt = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (i_key_code == KEY_ENTER) begin
                        w_pass_nxt       = r_sr;
                        w_pass_valid_nxt = 1'b1;
                        w_state_nxt      = ST_IDLE;
                        w_sr_nxt         = 16'h0000;
                        w_cnt_nxt        = 3'd0;
                    end else if (i_key_code == KEY_CLEAR) begin
                        w_state_nxt = ST_IDLE;
                        w_sr_nxt    = 16'h0000;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_key_error_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_sr_nxt    = 16'h0000;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end else if (w_expire) begin
            w_state_nxt = ST_IDLE;
            w_sr_nxt    = 16'h0000;
            w_cnt_nxt   = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sr         <= 16'h0000;
            r_cnt        <= 3'd0;
            r_pass       <= 16'h0000;
            r_pass_valid <= 1'b0;
            r_key_error  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sr         <= w_sr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pass       <= w_pass_nxt;
            r_pass_valid <= w_pass_valid_nxt;
            r_key_error  <= w_key_error_nxt;
        end
    end

`ifdef PIN_TIMEOUT_EN
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_tmo_cnt;
    logic        r_timeout;

    // Expiry is the decrement from 1 to 0, i.e. TIMEOUT_CYCLES edges after the last key.
    assign w_expire = !i_key_valid && (r_cnt != 3'd0) && (r_tmo_cnt == 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= TMO_LOAD;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (i_key_valid || w_expire) begin
                r_tmo_cnt <= TMO_LOAD;
            end else if (r_cnt != 3'd0) begin
                r_tmo_cnt <= r_tmo_cnt - 16'd1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_expire  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_pass       = r_pass;
    assign o_pass_valid = r_pass_valid;
    assign o_digit_cnt  = r_cnt;
    assign o_busy       = (r_cnt != 3'd0);
    assign o_key_error  = r_key_error;
    assign o_state      = r_state;

endmodule

// File: tb/tb_pin_entry_collector.sv
// Bench for pin_entry_collector: directed test-plan steps, then random keys checked
// against a digit-queue model of the keypad entry rules.
module tb_pin_entry_collector;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] pass;
  logic        pass_valid;
  logic [2:0]  digit_cnt;
  logic        busy;
  logic        key_error;
  logic        timeout;
  logic [1:0]  state;

  pin_entry_collector #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_key_valid  (key_valid),
    .i_key_code   (key_code),
    .o_pass       (pass),
    .o_pass_valid (pass_valid),
    .o_digit_cnt  (digit_cnt),
    .o_busy       (busy),
    .o_key_error  (key_error),
    .o_timeout    (timeout),
    .o_state      (state)
  );

  // clock/reset block
  always #5 clk = ~clk;

`ifdef PIN_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // reference model: digits held as a queue, idle cycles counted since last key
  int unsigned m_digits[$];
  logic [15:0] m_pass;
  logic        m_pv, m_err, m_tmo;
  int          m_idle;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_digits.delete();
    m_pass = 16'h0000;
    m_pv = 0; m_err = 0; m_tmo = 0;
    m_idle = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] c);
    logic [15:0] p;
    m_pv = 0; m_err = 0; m_tmo = 0;
    if (v) begin
      m_idle = 0;
      if (c <= 4'd9) begin
        if (m_digits.size() < 4) m_digits.push_back(int'(c));
        else m_err = 1;
      end else if (c == 4'hA) begin
        m_digits.delete();
      end else if (c == 4'hB && m_digits.size() == 4) begin
        p = 16'h0000;
        foreach (m_digits[i]) p = (p << 4) | 16'(m_digits[i]);
        m_pass = p;
        m_pv = 1;
        m_digits.delete();
      end else begin
        m_err = 1;
      end
    end else if (TMO_EN && m_digits.size() > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_digits.delete();
        m_tmo = 1;
        m_idle = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = m_digits.size();
    chk({tag, ".pass"},       pass,                16'(m_pass));
    chk({tag, ".pass_valid"}, 16'(pass_valid),     16'(m_pv));
    chk({tag, ".digit_cnt"},  16'(digit_cnt),      16'(n));
    chk({tag, ".busy"},       16'(busy),           16'(n != 0));
    chk({tag, ".key_error"},  16'(key_error),      16'(m_err));
    chk({tag, ".timeout"},    16'(timeout),        16'(m_tmo));
    chk({tag, ".state"},      16'(state),          (n == 0) ? 16'd0 : (n == 4) ? 16'd2 : 16'd1);
  endtask

  // driver tasks
  task automatic step(input logic v, input logic [3:0] c, input string tag);
    key_valid = v;
    key_code  = c;
    @(posedge clk);
    model_step(v, c);
    #1;
    check_all(tag);
  endtask

  task automatic key(input logic [3:0] c, input string tag);
    step(1'b1, c, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, tag);
  endtask

  task automatic do_reset(input logic v, input logic [3:0] c, input string tag);
    rst = 1'b1;
    key_valid = v;
    key_code  = c;
    @(posedge clk);
    model_reset();
    #1;
    check_all(tag);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] c;
    model_reset();
    do_reset(1'b0, 4'h0, "reset0");
    do_reset(1'b1, 4'h5, "reset1");

    key(4'h2, "a"); key(4'h4, "a"); key(4'h6, "a"); key(4'h8, "a");
    key(4'hB, "a_enter");
    chk("pin_2468", pass, 16'h2468);
    chk("pv_2468", 16'(pass_valid), 16'd1);
    idle(1, "a_after");
    chk("pv_one_cycle", 16'(pass_valid), 16'd0);

    key(4'h1, "b"); key(4'h2, "b");
    key(4'hB, "b_enter");
    chk("early_enter_err", 16'(key_error), 16'd1);
    chk("early_enter_cnt", 16'(digit_cnt), 16'd2);
    key(4'hA, "b_clear");
    chk("clear_cnt", 16'(digit_cnt), 16'd0);

    key(4'h9, "c"); key(4'h9, "c"); key(4'h9, "c"); key(4'h9, "c");
    key(4'h5, "c_fifth");
    chk("fifth_err", 16'(key_error), 16'd1);
    key(4'hB, "c_enter");
    chk("pin_9999", pass, 16'h9999);
    key(4'h3, "back_to_back");

    key(4'hA, "d_clr"); key(4'hE, "d_rsvd");
    chk("rsvd_idle_err", 16'(key_error), 16'd1);
    key(4'hA, "d_clear_idle");
    chk("clear_idle_noerr", 16'(key_error), 16'd0);

    key(4'h3, "e_key");
    idle(TMO - 1, "e_wait");
    idle(1, "e_expire");
    if (TMO_EN) chk("tmo_pulse", 16'(timeout), 16'd1);
    else chk("no_tmo_persist", 16'(digit_cnt), 16'd1);
    key(4'hA, "e_clr");
    key(4'h3, "f_key");
    idle(TMO - 1, "f_wait");
    key(4'h7, "f_race");
    chk("race_cnt", 16'(digit_cnt), 16'd2);
    chk("race_no_tmo", 16'(timeout), 16'd0);
    idle(TMO + 2, "f_drain");
    key(4'hA, "f_clr");

    key(4'h1, "g"); key(4'h2, "g"); key(4'h3, "g");
    do_reset(1'b0, 4'h0, "g_rst");
    chk("rst_pass", pass, 16'h0000);
    key(4'h4, "h"); key(4'h3, "h"); key(4'h2, "h"); key(4'h1, "h");
    key(4'hB, "h_enter");
    chk("pin_4321", pass, 16'h4321);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "rnd_rst");
      end else if ($urandom_range(0, 99) < 8) begin
        idle($urandom_range(1, TMO + 2), "rnd_idle");
      end else if ($urandom_range(0, 99) < 75) begin
        case ($urandom_range(0, 19))
          0:       c = 4'hA;
          1, 2, 3: c = 4'hB;
          4:       c = 4'($urandom_range(12, 15));
          default: c = 4'($urandom_range(0, 9));
        endcase
        key(c, "rnd_key");
      end else begin
        idle(1, "rnd_gap");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
